// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that grants one requester at a time for a bounded hold,
// drives a registered mux select, and routes the granted requester's bit to f.
module rr_mux_arbiter #(
  parameter int unsigned INS      = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INS-1:0]           req,
  input  logic [INS-1:0]           w,
  output logic [INS-1:0]           gnt,
  output logic [$clog2(INS)-1:0]   sel,
  output logic                     busy,
  output logic                     f
);

  localparam int unsigned SelW  = $clog2(INS);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [INS-1:0]     gnt_q, gnt_d;
  logic [SelW-1:0]    sel_q, sel_d;
  logic [SelW-1:0]    last_q, last_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic               busy_q, busy_d;

  logic [SelW-1:0]    ref_sel;
  logic [SelW-1:0]    hi_idx, lo_idx, win_idx;
  logic               hi_found, lo_found;
  logic               any_req;
  logic               release_grant;

  // Search starts just past the current holder while granted (it becomes last on
  // release), otherwise just past the last served requester. Splitting the scan
  // into "above ref" and "at or below ref" avoids modulo arithmetic for any INS.
  always_comb begin
    ref_sel  = (state_q == StGrant) ? sel_q : last_q;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < int'(INS); i++) begin
      if (req[i] && !hi_found && (i > int'(ref_sel))) begin
        hi_found = 1'b1;
        hi_idx   = SelW'(i);
      end
      if (req[i] && !lo_found && (i <= int'(ref_sel))) begin
        lo_found = 1'b1;
        lo_idx   = SelW'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  assign any_req       = |req;
  assign release_grant = !req[sel_q] || (hold_cnt_q == HoldW'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    busy_d     = busy_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d    = StGrant;
          sel_d      = win_idx;
          gnt_d      = {{(INS-1){1'b0}}, 1'b1} << win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        if (release_grant) begin
          last_d     = sel_q;
          hold_cnt_d = '0;
          if (any_req) begin
            sel_d = win_idx;
            gnt_d = {{(INS-1){1'b0}}, 1'b1} << win_idx;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        gnt_d      = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      sel_q      <= '0;
      last_q     <= SelW'(INS - 1);
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign f    = busy_q & w[sel_q];

endmodule
